fetch_pc_sequencer_super: RTL and testbench
===========================================

Name: fetch_pc_sequencer_super

Overview:
- Next-PC stage of the 3-wide superscalar front end; sits directly downstream of the jump controller.
- Owns the fetch PC and presents three sequential slot PCs to the instruction memory and the jump controller.
- Consumes the per-slot jump/jalr decisions, computes JAL/branch targets, and masks the slots that follow the first taken transfer.
- Stalls on JALR until the backend resolves the target; applies backend mispredict redirects.

Parameters:
- size, 32, address/instruction width
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instruction_0/1/2  in  size  fetched instruction per slot
- jump_0/1/2  in  1  slot is JAL or predicted-taken branch
- jalr_0/1/2  in  1  slot is JALR
- fetch_ready_i  in  1  decode buffer accepts the current group
- redirect_valid_i  in  1  backend mispredict/flush
- redirect_pc_i  in  size  correct PC on redirect
- jalr_resolve_valid_i  in  1  JALR target available
- jalr_target_i  in  size  resolved JALR target
- current_pc_0/1/2  out  size  pc_q, pc_q+4, pc_q+8
- slot_valid_o  out  3  per-slot valid mask
- fetch_valid_o  out  1  group presented to decode
- jalr_wait_o  out  1  state==JALR_WAIT

Behaviour:
- Reset (sync, active-high): pc_q=RESET_PC, state=RUN. While reset is high: fetch_valid_o=0, slot_valid_o=0, jalr_wait_o=0, current_pc_k=RESET_PC+4k.
- Slot PCs: current_pc_k=pc_q+4k. All arithmetic is modulo 2^size, so wrap-around is silent (pc_q=FFFF_FFFC gives slot1=0, slot2=4).
- First transfer: f = lowest k with jump_k|jalr_k. Otherwise none.
- slot_valid_o: slots 0..f set; slots >f clear. With no transfer: 3'b111.
- Target per slot:
  - opcode 1101111: current_pc_k + J-imm (sign-extended, bit0=0).
  - opcode 1100011: current_pc_k + B-imm.
- States:
  - RUN: fetch_valid_o=1.
  - JALR_WAIT: fetch_valid_o=0, slot_valid_o=0.
- Advance: occurs only on fetch_valid_o & fetch_ready_i. pc_q takes:
  - target_f if jump_f;
  - pc_q+12 if no transfer;
  - if jalr_f: pc_q is held and the state moves to JALR_WAIT.
- Stall: fetch_ready_i=0 in RUN holds pc_q and the state; outputs remain stable.
- JALR_WAIT: on jalr_resolve_valid_i, pc_q={jalr_target_i[size-1:1],1'b0} and state goes to RUN. The first new group is presented the next cycle.
- Priority, highest first: reset > redirect_valid_i > jalr_resolve_valid_i > advance.
  - Redirect in any state: pc_q=redirect_pc_i, state=RUN, current group dropped, even if fetch_ready_i=1.
  - Redirect and resolve in the same cycle: redirect wins.
- Latency: a target is visible on current_pc_0 one cycle after the accepting edge.
- Slot inputs are ignored while in JALR_WAIT.
- Targets are not alignment-checked; misaligned PCs pass through to fetch.

Optional Feature:
- Macro: FETCH_SEQ_PERF_CNT_EN.
- Defined: adds 32-bit output ports perf_groups_o, perf_taken_o, perf_jalr_stall_o.
  - perf_groups_o counts accepted groups.
  - perf_taken_o counts accepted groups with jump_f.
  - perf_jalr_stall_o counts cycles spent in JALR_WAIT.
  - All counters reset to 0, wrap at 2^32, and are unaffected by redirect.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fetch_super_pkg:
  - state enum fetch_state_t {RUN, JALR_WAIT};
  - FETCH_WIDTH=3, INSTR_BYTES=4;
  - OPC_JAL=7'b1101111, OPC_BRANCH=7'b1100011, OPC_JALR=7'b1100111.
- Sub-module fetch_target_gen (pc, instruction -> target): pure combinational, instantiated once per slot.

Test Plan:
- Reset, then fetch_ready_i=1 with no transfers → current_pc_0 steps 0, 12, 24; slot_valid_o=3'b111; fetch_valid_o=1.
- pc_q=0x100, jump_1=1, instruction_1=JAL +0x40 → slot_valid_o=3'b011; next current_pc_0=0x144.
- pc_q=0x200, jalr_0=1 → slot_valid_o=3'b001. Then jalr_wait_o=1 and fetch_valid_o=0 for 3 cycles. Resolve with 0x301 → current_pc_0=0x300 in RUN.
- In JALR_WAIT, redirect_valid_i and jalr_resolve_valid_i in the same cycle with redirect_pc_i=0x500 → pc_q=0x500, RUN.
- fetch_ready_i=0 for 4 cycles with jump_2=1 → pc_q and outputs are held. On release, one advance to target_2.
- pc_q=0xFFFF_FFFC with no transfer → current_pc_1=0x0, current_pc_2=0x4; after accept, pc_q=0x8.

Source files
------------

// File: rtl/fetch_pc_sequencer_super_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_super_pkg: shared types and constants for the next-PC stage. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fetch_super_pkg;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    JALR_WAIT = 1'b1
  } fetch_state_t;

  localparam int FETCH_WIDTH = 3;
  localparam int INSTR_BYTES = 4;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Slots up to and including the first transfer stay live; all ones if none.
  function automatic logic [FETCH_WIDTH-1:0] upto_first(input logic [FETCH_WIDTH-1:0] xfer);
    logic [FETCH_WIDTH-1:0] res;
    logic                   seen;
    res  = '0;
    seen = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (!seen) res[k] = 1'b1;
      if (xfer[k]) seen = 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_sequencer_super_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pc_sequencer_super_if: slot, handshake and redirect bundle.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fetch_pc_sequencer_super_if #(
  parameter int size = 32
);
  logic [size-1:0] instruction_0, instruction_1, instruction_2;
  logic            jump_0, jump_1, jump_2;
  logic            jalr_0, jalr_1, jalr_2;
  logic            fetch_ready_i;
  logic            redirect_valid_i;
  logic [size-1:0] redirect_pc_i;
  logic            jalr_resolve_valid_i;
  logic [size-1:0] jalr_target_i;
  logic [size-1:0] current_pc_0, current_pc_1, current_pc_2;
  logic [2:0]      slot_valid_o;
  logic            fetch_valid_o;
  logic            jalr_wait_o;

  modport master (
    output instruction_0, instruction_1, instruction_2,
    output jump_0, jump_1, jump_2, jalr_0, jalr_1, jalr_2,
    output fetch_ready_i, redirect_valid_i, redirect_pc_i,
    output jalr_resolve_valid_i, jalr_target_i,
    input  current_pc_0, current_pc_1, current_pc_2,
    input  slot_valid_o, fetch_valid_o, jalr_wait_o
  );

  modport slave (
    input  instruction_0, instruction_1, instruction_2,
    input  jump_0, jump_1, jump_2, jalr_0, jalr_1, jalr_2,
    input  fetch_ready_i, redirect_valid_i, redirect_pc_i,
    input  jalr_resolve_valid_i, jalr_target_i,
    output current_pc_0, current_pc_1, current_pc_2,
    output slot_valid_o, fetch_valid_o, jalr_wait_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_sequencer_super_target_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_target_gen: JAL / branch target for one slot (combinational).|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_target_gen
  import fetch_super_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [size-1:0] pc_i,
  input  logic [size-1:0] instruction_i,
  output logic [size-1:0] target_o
);

  logic [size-1:0] j_imm;
  logic [size-1:0] b_imm;

  assign j_imm = {{(size-20){instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                  instruction_i[30:21], 1'b0};
  assign b_imm = {{(size-12){instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                  instruction_i[11:8], 1'b0};

  // Non-transfer opcodes fall through to the next sequential slot.
  always_comb begin
    target_o = pc_i + size'(INSTR_BYTES);
    case (instruction_i[6:0])
      OPC_JAL:    target_o = pc_i + j_imm;
      OPC_BRANCH: target_o = pc_i + b_imm;
      default:    target_o = pc_i + size'(INSTR_BYTES);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_sequencer_super.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pc_sequencer_super: 3-wide next-PC stage with JALR stall.    |
// | Optional FETCH_SEQ_PERF_CNT_EN adds perf counters. Revision: 1.0   |
// +--------------------------------------------------------------------+
module fetch_pc_sequencer_super
  import fetch_super_pkg::*;
#(
  parameter int              size     = 32,
  parameter logic [size-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  fetch_pc_sequencer_super_if.slave bus
`ifdef FETCH_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_groups_o,
  output logic [31:0] perf_taken_o,
  output logic [31:0] perf_jalr_stall_o
`endif
);

  fetch_state_t           state_q, state_d;
  logic [size-1:0]        pc_q, pc_d;
  logic [size-1:0]        base_pc;
  logic [size-1:0]        slot_pc [FETCH_WIDTH];
  logic [size-1:0]        target  [FETCH_WIDTH];
  logic [size-1:0]        instr   [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] jump_v, jalr_v, xfer;
  logic [1:0]             first_idx;
  logic                   has_xfer, jump_f, jalr_f, fire;

  assign instr[0] = bus.instruction_0;
  assign instr[1] = bus.instruction_1;
  assign instr[2] = bus.instruction_2;
  assign jump_v   = {bus.jump_2, bus.jump_1, bus.jump_0};
  assign jalr_v   = {bus.jalr_2, bus.jalr_1, bus.jalr_0};
  assign xfer     = jump_v | jalr_v;

  // Slot PCs read RESET_PC while reset is held so they are defined from cycle 0.
  assign base_pc = reset ? RESET_PC : pc_q;

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    assign slot_pc[k] = base_pc + size'(k * INSTR_BYTES);
    fetch_target_gen #(.size(size)) u_target_gen (
      .pc_i          (slot_pc[k]),
      .instruction_i (instr[k]),
      .target_o      (target[k])
    );
  end

  always_comb begin
    has_xfer  = 1'b0;
    first_idx = 2'd0;
    for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
      if (xfer[k]) begin
        has_xfer  = 1'b1;
        first_idx = 2'(k);
      end
    end
  end

  assign jump_f = has_xfer & jump_v[first_idx];
  assign jalr_f = has_xfer & ~jump_v[first_idx] & jalr_v[first_idx];

  assign bus.fetch_valid_o = ~reset & (state_q == RUN);
  assign bus.jalr_wait_o   = ~reset & (state_q == JALR_WAIT);
  assign bus.slot_valid_o  = bus.fetch_valid_o ? upto_first(xfer) : '0;
  assign bus.current_pc_0  = slot_pc[0];
  assign bus.current_pc_1  = slot_pc[1];
  assign bus.current_pc_2  = slot_pc[2];
  assign fire              = bus.fetch_valid_o & bus.fetch_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redirect_valid_i) begin
      state_d = RUN;
      pc_d    = bus.redirect_pc_i;
    end else begin
      case (state_q)
        RUN: begin
          if (fire) begin
            if (jump_f)      pc_d    = target[first_idx];
            else if (jalr_f) state_d = JALR_WAIT;
            else             pc_d    = pc_q + size'(FETCH_WIDTH * INSTR_BYTES);
          end
        end
        JALR_WAIT: begin
          if (bus.jalr_resolve_valid_i) begin
            state_d = RUN;
            pc_d    = {bus.jalr_target_i[size-1:1], 1'b0};
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic accept;
  assign accept = fire & ~bus.redirect_valid_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_groups_o     <= '0;
      perf_taken_o      <= '0;
      perf_jalr_stall_o <= '0;
    end else begin
      if (accept)               perf_groups_o     <= perf_groups_o + 32'd1;
      if (accept && jump_f)     perf_taken_o      <= perf_taken_o + 32'd1;
      if (state_q == JALR_WAIT) perf_jalr_stall_o <= perf_jalr_stall_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_sequencer_super.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_pc_sequencer_super: vectors, corner sequences, random run.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fetch_pc_sequencer_super;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pc_sequencer_super_if #(.size(32)) bus ();

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [31:0] perf_groups, perf_taken, perf_jalr_stall;
`endif

  fetch_pc_sequencer_super #(.size(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_SEQ_PERF_CNT_EN
    ,
    .perf_groups_o     (perf_groups),
    .perf_taken_o      (perf_taken),
    .perf_jalr_stall_o (perf_jalr_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  jmp;
    logic [2:0]  jr;
    logic [2:0]  br;
    int          off0, off1, off2;
    logic [2:0]  sv;
    bit          wait_exp;
    logic [31:0] nxt;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Encode a JAL or branch carrying the given byte offset.
  function automatic logic [31:0] enc(input bit br, input int off);
    logic [31:0] o;
    o = off;
    if (br) return {o[12], o[10:5], 5'd2, 5'd1, 3'b001, o[4:1], o[11], 7'b1100011};
    else    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic set_slot(input int k, input bit j, input bit jr, input logic [31:0] ins);
    case (k)
      0: begin bus.jump_0 = j; bus.jalr_0 = jr; bus.instruction_0 = ins; end
      1: begin bus.jump_1 = j; bus.jalr_1 = jr; bus.instruction_1 = ins; end
      default: begin bus.jump_2 = j; bus.jalr_2 = jr; bus.instruction_2 = ins; end
    endcase
  endtask

  task automatic clear_slots();
    for (int k = 0; k < 3; k++) set_slot(k, 1'b0, 1'b0, 32'h0000_0013);
  endtask

  task automatic goto_pc(input logic [31:0] pc);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = pc;
    @(negedge clk);
    bus.redirect_valid_i = 1'b0;
  endtask

  task automatic chk_group(input string nm, input logic [31:0] pc, input logic [2:0] sv);
    chk({nm, " pc0"}, bus.current_pc_0, pc);
    chk({nm, " pc1"}, bus.current_pc_1, pc + 32'd4);
    chk({nm, " pc2"}, bus.current_pc_2, pc + 32'd8);
    chk({nm, " slot_valid"}, {29'd0, bus.slot_valid_o}, {29'd0, sv});
    chk({nm, " fetch_valid"}, {31'd0, bus.fetch_valid_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] m_pc, rpc, rtgt, exp_pc;
    logic [2:0]  rj, rjr, es;
    bit          m_wait, rdy, redir, res;
    int          o [3];
    int          f, r, off;

    reset = 1'b1;
    clear_slots();
    bus.fetch_ready_i        = 1'b0;
    bus.redirect_valid_i     = 1'b0;
    bus.redirect_pc_i        = '0;
    bus.jalr_resolve_valid_i = 1'b0;
    bus.jalr_target_i        = '0;

    vt[0] = '{32'h0000_0100, 3'b010, 3'b000, 3'b000, 0, 32'h40, 0, 3'b011, 1'b0, 32'h0000_0144};
    vt[1] = '{32'h0000_0200, 3'b000, 3'b001, 3'b000, 0, 0, 0, 3'b001, 1'b1, 32'h0};
    vt[2] = '{32'h0000_0300, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b111, 1'b0, 32'h0000_030C};
    vt[3] = '{32'h0000_0400, 3'b100, 3'b000, 3'b100, 0, 0, -8, 3'b111, 1'b0, 32'h0000_0400};
    vt[4] = '{32'h0000_1000, 3'b001, 3'b000, 3'b000, -4096, 0, 0, 3'b001, 1'b0, 32'h0000_0000};
    vt[5] = '{32'hFFFF_FFFC, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b111, 1'b0, 32'h0000_0008};
    vt[6] = '{32'h0000_0500, 3'b110, 3'b000, 3'b010, 0, 32'h10, 32'h80, 3'b011, 1'b0, 32'h0000_0514};
    vt[7] = '{32'h0000_0600, 3'b100, 3'b010, 3'b000, 0, 0, 32'h20, 3'b011, 1'b1, 32'h0};
    vt[8] = '{32'h0000_0700, 3'b001, 3'b000, 3'b001, 4094, 0, 0, 3'b001, 1'b0, 32'h0000_16FE};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst fetch_valid", {31'd0, bus.fetch_valid_o}, 32'd0);
    chk("rst slot_valid", {29'd0, bus.slot_valid_o}, 32'd0);
    chk("rst jalr_wait", {31'd0, bus.jalr_wait_o}, 32'd0);
    chk("rst pc0", bus.current_pc_0, 32'h0);
    chk("rst pc2", bus.current_pc_2, 32'h8);

    // Sequential stepping
    @(negedge clk);
    reset = 1'b0;
    bus.fetch_ready_i = 1'b1;
    #1 chk_group("seq0", 32'd0, 3'b111);
    @(negedge clk);
    #1 chk_group("seq1", 32'd12, 3'b111);
    @(negedge clk);
    #1 chk_group("seq2", 32'd24, 3'b111);
    bus.fetch_ready_i = 1'b0;

    // Table-driven single-group vectors
    for (int i = 0; i < 9; i++) begin
      goto_pc(vt[i].pc);
      for (int k = 0; k < 3; k++) begin
        off = (k == 0) ? vt[i].off0 : (k == 1) ? vt[i].off1 : vt[i].off2;
        set_slot(k, vt[i].jmp[k], vt[i].jr[k],
                 vt[i].jmp[k] ? enc(vt[i].br[k], off) : 32'h0000_0013);
      end
      bus.fetch_ready_i = 1'b1;
      #1 chk_group($sformatf("vec%0d", i), vt[i].pc, vt[i].sv);
      @(negedge clk);
      clear_slots();
      bus.fetch_ready_i = 1'b0;
      #1;
      if (vt[i].wait_exp) begin
        chk($sformatf("vec%0d jalr_wait", i), {31'd0, bus.jalr_wait_o}, 32'd1);
        chk($sformatf("vec%0d wait fv", i), {31'd0, bus.fetch_valid_o}, 32'd0);
        chk($sformatf("vec%0d wait sv", i), {29'd0, bus.slot_valid_o}, 32'd0);
        bus.jalr_resolve_valid_i = 1'b1;
        bus.jalr_target_i        = vt[i].pc;
        @(negedge clk);
        bus.jalr_resolve_valid_i = 1'b0;
      end else begin
        chk($sformatf("vec%0d next pc", i), bus.current_pc_0, vt[i].nxt);
        chk($sformatf("vec%0d jalr_wait", i), {31'd0, bus.jalr_wait_o}, 32'd0);
      end
    end

    // JALR stall for three cycles, then resolve with an odd target
    goto_pc(32'h200);
    set_slot(0, 1'b0, 1'b1, 32'h0000_0067);
    bus.fetch_ready_i = 1'b1;
    #1 chk("jalr sv", {29'd0, bus.slot_valid_o}, 32'd1);
    @(negedge clk);
    clear_slots();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("jalr hold wait", {31'd0, bus.jalr_wait_o}, 32'd1);
      chk("jalr hold fv", {31'd0, bus.fetch_valid_o}, 32'd0);
      @(negedge clk);
    end
    bus.jalr_resolve_valid_i = 1'b1;
    bus.jalr_target_i        = 32'h301;
    @(negedge clk);
    bus.jalr_resolve_valid_i = 1'b0;
    bus.fetch_ready_i        = 1'b0;
    #1;
    chk("jalr resolved pc0", bus.current_pc_0, 32'h300);
    chk("jalr resolved fv", {31'd0, bus.fetch_valid_o}, 32'd1);
    chk("jalr resolved wait", {31'd0, bus.jalr_wait_o}, 32'd0);

    // Redirect beats resolve in the same cycle
    goto_pc(32'h200);
    set_slot(0, 1'b0, 1'b1, 32'h0000_0067);
    bus.fetch_ready_i = 1'b1;
    @(negedge clk);
    clear_slots();
    bus.redirect_valid_i     = 1'b1;
    bus.redirect_pc_i        = 32'h500;
    bus.jalr_resolve_valid_i = 1'b1;
    bus.jalr_target_i        = 32'h900;
    @(negedge clk);
    bus.redirect_valid_i     = 1'b0;
    bus.jalr_resolve_valid_i = 1'b0;
    bus.fetch_ready_i        = 1'b0;
    #1;
    chk("redir+res pc0", bus.current_pc_0, 32'h500);
    chk("redir+res wait", {31'd0, bus.jalr_wait_o}, 32'd0);

    // Stall with jump in slot 2, then a single advance
    goto_pc(32'h800);
    set_slot(2, 1'b1, 1'b0, enc(1'b0, 32'h20));
    for (int c = 0; c < 4; c++) begin
      #1 chk_group("stall", 32'h800, 3'b111);
      @(negedge clk);
    end
    bus.fetch_ready_i = 1'b1;
    @(negedge clk);
    bus.fetch_ready_i = 1'b0;
    clear_slots();
    #1 chk("stall release pc0", bus.current_pc_0, 32'h828);
    @(negedge clk);
    #1 chk("stall single adv", bus.current_pc_0, 32'h828);

    // Randomized run against a behavioural model
    goto_pc(32'h1000);
    m_pc   = 32'h1000;
    m_wait = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rj  = '0;
      rjr = '0;
      for (int k = 0; k < 3; k++) begin
        r    = $urandom_range(0, 9);
        o[k] = 0;
        if (r <= 1) begin
          o[k] = (int'($urandom_range(0, 1048575)) - 524288) * 2;
          rj[k] = 1'b1;
          set_slot(k, 1'b1, 1'b0, enc(1'b0, o[k]));
        end else if (r == 2) begin
          o[k] = (int'($urandom_range(0, 4095)) - 2048) * 2;
          rj[k] = 1'b1;
          set_slot(k, 1'b1, 1'b0, enc(1'b1, o[k]));
        end else if (r == 3) begin
          rjr[k] = 1'b1;
          set_slot(k, 1'b0, 1'b1, 32'h0000_0067);
        end else begin
          set_slot(k, 1'b0, 1'b0, $urandom);
        end
      end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = $urandom;
      res   = m_wait && ($urandom_range(0, 2) == 0);
      rtgt  = $urandom;
      bus.fetch_ready_i        = rdy;
      bus.redirect_valid_i     = redir;
      bus.redirect_pc_i        = rpc;
      bus.jalr_resolve_valid_i = res;
      bus.jalr_target_i        = rtgt;
      #1;
      f = -1;
      for (int k = 0; k < 3; k++) if (f < 0 && (rj[k] || rjr[k])) f = k;
      es = m_wait ? 3'b000 : (f < 0) ? 3'b111 : 3'((1 << (f + 1)) - 1);
      chk("rnd pc0", bus.current_pc_0, m_pc);
      chk("rnd pc1", bus.current_pc_1, m_pc + 32'd4);
      chk("rnd pc2", bus.current_pc_2, m_pc + 32'd8);
      chk("rnd slot_valid", {29'd0, bus.slot_valid_o}, {29'd0, es});
      chk("rnd fetch_valid", {31'd0, bus.fetch_valid_o}, {31'd0, !m_wait});
      chk("rnd jalr_wait", {31'd0, bus.jalr_wait_o}, {31'd0, m_wait});
      if (redir) begin
        m_pc   = rpc;
        m_wait = 1'b0;
      end else if (m_wait) begin
        if (res) begin
          m_pc   = rtgt & 32'hFFFF_FFFE;
          m_wait = 1'b0;
        end
      end else if (rdy) begin
        if (f < 0) m_pc = m_pc + 32'd12;
        else if (rj[f]) begin
          exp_pc = m_pc + 32'(4 * f) + 32'(o[f]);
          m_pc   = exp_pc;
        end else m_wait = 1'b1;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
